// File: rtl/clock_divider_multi_if.sv
// Divisor programming and readback bus for clock_divider_multi.
// Write is a single-cycle strobe; readback is combinational and never stalls.
interface clock_divider_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_div;
    logic [CH_W-1:0]  rd_ch;
    logic [CNT_W-1:0] rd_div;

    modport master (
        output wr_en,
        output wr_ch,
        output wr_div,
        output rd_ch,
        input  rd_div
    );

    modport slave (
        input  wr_en,
        input  wr_ch,
        input  wr_div,
        input  rd_ch,
        output rd_div
    );
endinterface

// File: rtl/clock_divider_multi.sv
// NUM_CH independent programmable dividers: registered tick strobe and 50% clk_out per channel.
// Outputs update one edge after the deciding inputs; no backpressure, writes always accepted.
module clock_divider_multi #(
    parameter int               NUM_CH      = 4,
    parameter int               CNT_W       = 32,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(25000000)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    ch_en,
    input  logic                 sync,
    clock_divider_multi_if.slave bus,
    output logic [NUM_CH-1:0]    clk_out,
    output logic [NUM_CH-1:0]    tick
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] div_arr [NUM_CH];
    logic             wr_ok;

    // Out-of-range channel numbers only exist when NUM_CH is not a power of two.
    assign wr_ok = bus.wr_en && (32'(bus.wr_ch) < NUM_CH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] div_q;
        logic [CNT_W-1:0] cnt_q;
        logic             clk_q;
        logic             tick_q;
        logic             wr_hit;
        logic             park;

        assign wr_hit = wr_ok && (32'(bus.wr_ch) == 32'(i));
        assign park   = !ch_en[i] || (div_q == '0) || sync;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                div_q  <= DEFAULT_DIV;
                cnt_q  <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else if (wr_hit) begin
                // A write restarts the period and suppresses any coincident terminal tick.
                div_q  <= bus.wr_div;
                cnt_q  <= '0;
                tick_q <= 1'b0;
                if (!ch_en[i] || sync) begin
                    clk_q <= 1'b0;
                end
            end else if (park) begin
                cnt_q  <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else if (cnt_q == div_q - ONE) begin
                cnt_q  <= '0;
                clk_q  <= ~clk_q;
                tick_q <= 1'b1;
            end else begin
                cnt_q  <= cnt_q + ONE;
                tick_q <= 1'b0;
            end
        end

        assign div_arr[i]  = div_q;
        assign clk_out[i]  = clk_q;
        assign tick[i]     = tick_q;
    end

    always_comb begin
        bus.rd_div = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (32'(bus.rd_ch) == 32'(i)) begin
                bus.rd_div = div_arr[i];
            end
        end
    end
endmodule
